seq_det_scheduler: RTL and testbench
====================================

// Module: seq_det_scheduler
// PURPOSE
// - Shares one serial sequence detector (1-bit in, Mealy seq pulse, async active-high reset) among NUM_REQ requesters.
// - Round-robin grants one requester, latches its DATA_W-bit word and clears the detector.
// - Then shifts the word into the detector MSB-first, counts seq pulses and returns {id, count} over a valid/ready response.
// - Sits between the requester fabric and the detector instance; this block is the detector's only driver.
// PARAMETERS
// - NUM_REQ  4  number of requesters (>=2)
// - DATA_W   8  bits per word shifted into the detector
// - CNT_W    4  width of rsp_count; count saturates at 2**CNT_W-1
// PORTS
// - clk        in   1                  single clock, rising edge
// - rst_n      in   1                  asynchronous, active-low reset
// - req_valid  in   NUM_REQ            per-requester word valid
// - req_data   in   NUM_REQ*DATA_W     word r at [r*DATA_W +: DATA_W]
// - req_ready  out  NUM_REQ            one-hot accept pulse; transfer when valid&ready
// - det_rst    out  1                  detector reset (active-high)
// - det_in     out  1                  serial bit to detector
// - det_seq    in   1                  detector match, combinational on det_in (same cycle)
// - rsp_valid  out  1                  result valid; held until rsp_ready
// - rsp_ready  in   1                  result accepted
// - rsp_id     out  $clog2(NUM_REQ)    granted requester index
// - rsp_count  out  CNT_W              matches seen in word
// - busy       out  1                  high in any state except IDLE
// BEHAVIOUR
// - Reset (rst_n=0, async): state IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_count=0, det_in=0, busy=0, rr pointer=NUM_REQ-1 (req 0 has first priority).
// - Reset timing: det_rst = ~rst_n | (state==CLEAR), combinational.
// - FSM IDLE->CLEAR->SHIFT->REPORT->IDLE.
// - IDLE: if any req_valid, grant the first valid index after the rr pointer (wrapping).
//   - Pulse req_ready[g] for that one cycle, latch data, set rsp_id=g and rr pointer=g, clear count, go CLEAR.
//   - req_ready is 0 in all other states.
// - CLEAR: det_rst=1 and det_in=0 for exactly one cycle, bit index=DATA_W-1, go SHIFT.
// - SHIFT: det_in=data[idx]. If det_seq=1 in this cycle, count+=1, saturating (no wrap).
//   - After idx 0 is shifted, go REPORT.
//   - det_seq is ignored outside SHIFT.
// - REPORT: rsp_valid=1; rsp_id and rsp_count are stable while rsp_valid=1 and rsp_ready=0.
//   - On rsp_valid&rsp_ready, drop rsp_valid and go IDLE.
//   - Nothing new is accepted until then.
// - Latency: accept at cycle T gives CLEAR at T+1, SHIFT at T+2..T+1+DATA_W, and rsp_valid first high at T+2+DATA_W.
//   - Next accept no earlier than the cycle after the response handshake.
// - A req_valid drop while not granted is legal; the arbiter reevaluates each IDLE cycle.
// - Reset mid-operation aborts the word: no response, detector cleared, pointer restored.
// - det_in = 0 whenever not in SHIFT.
// CONFIGURATION
// - SEQ_SCHED_CHAIN_EN defined:
//   - In IDLE, if the grant equals the previous grant and a previous word completed since reset, skip CLEAR.
//   - Go straight to SHIFT; detector state carries over, so latency is one cycle shorter.
// - SEQ_SCHED_CHAIN_EN undefined: CLEAR always runs, and every word is detected independently.
// TESTING
// - Word 8'b1011_0100 on req 0 only -> req_ready[0] one pulse; rsp_valid 10 cycles after accept; rsp_id=0, rsp_count=1.
// - Word 8'h00 on req 3 -> rsp_id=3, rsp_count=0; det_seq never sampled high.
// - Req 0 and req 2 both valid continuously, rsp_ready=1 -> grant order 0,2,0,2; req 1/3 never get ready.
// - Req 1 sends 8'b0000_1011 then 8'b0110_0000 -> counts 0 then 0 (CLEAR isolates words).
//   - Same with SEQ_SCHED_CHAIN_EN -> counts 0 then 1, and the second response is 1 cycle earlier.
// - rsp_ready held 0 for 5 cycles in REPORT -> rsp_valid/id/count stable; no req_ready while a request is pending.
// - rst_n low during SHIFT bit 3 -> same cycle: det_rst=1, busy=0, rsp_valid=0; no response emitted; next grant goes to req 0.

Source files
------------

// File: rtl/seq_det_scheduler.sv
// Round-robin scheduler sharing one serial sequence detector among requesters.
// Define SEQ_SCHED_CHAIN_EN to skip CLEAR when the same requester is regranted.
module seq_det_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        det_rst,
   output logic                        det_in,
   input  logic                        det_seq,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
   output logic [CNT_W-1:0]            rsp_count,
   output logic                        busy
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int IW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDW-1:0] PTR_RST = IDW'(NUM_REQ - 1);
   localparam logic [IW-1:0]  IDX_TOP = IW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, REPORT} state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    id_q, id_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              vld_q, vld_d;
   logic              done_q, done_d;
   logic [IDW-1:0]    gnt_idx;
   logic [IDW-1:0]    cand;
   logic              gnt_found;

   // first valid requester strictly after the pointer, wrapping
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = IDW'((int'(ptr_q) + i) % NUM_REQ);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      id_d      = id_q;
      data_d    = data_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      vld_d     = vld_q;
      done_d    = done_q;
      req_ready = '0;
      unique case (state_q)
         IDLE: begin
            if (gnt_found && rst_n) begin
               req_ready[gnt_idx] = 1'b1;
               data_d  = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
               id_d    = gnt_idx;
               ptr_d   = gnt_idx;
               cnt_d   = '0;
               idx_d   = IDX_TOP;
               state_d = CLEAR;
`ifdef SEQ_SCHED_CHAIN_EN
               if (done_q && gnt_idx == ptr_q)
                  state_d = SHIFT;
`endif
            end
         end
         CLEAR: begin
            idx_d   = IDX_TOP;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (det_seq && cnt_q != '1)
               cnt_d = cnt_q + 1'b1;
            if (idx_q == '0) begin
               vld_d   = 1'b1;
               state_d = REPORT;
            end else begin
               idx_d = idx_q - 1'b1;
            end
         end
         REPORT: begin
            if (rsp_ready) begin
               vld_d   = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= PTR_RST;
         id_q    <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         done_q  <= done_d;
      end
   end

   assign det_rst   = ~rst_n | (state_q == CLEAR);
   assign det_in    = (state_q == SHIFT) & data_q[idx_q];
   assign busy      = (state_q != IDLE);
   assign rsp_valid = vld_q;
   assign rsp_id    = id_q;
   assign rsp_count = cnt_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler with a behavioural "1101" Mealy detector.
module tb_seq_det_scheduler;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic [NR-1:0] req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0] req_ready;
   logic          det_rst;
   logic          det_in;
   logic          det_seq;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [1:0]    rsp_id;
   logic [CW-1:0] rsp_count;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;
   int ptr_m = NR - 1;
   int seq_hi = 0;
   logic [2:0] hist;

   seq_det_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .det_rst(det_rst), .det_in(det_in), .det_seq(det_seq),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_count(rsp_count), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // overlapping "1101" detector, reacts to det_in within the cycle
   always_ff @(posedge clk or posedge det_rst)
      if (det_rst) hist <= 3'b000;
      else         hist <= {hist[1:0], det_in};
   assign det_seq = (hist == 3'b110) && det_in;

   always @(negedge clk)
      if (det_seq) seq_hi <= seq_hi + 1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic int n1101(input logic [7:0] w);
      int n = 0;
      for (int s = 7; s >= 3; s--)
         if (((w >> (s - 3)) & 8'h0F) == 8'h0D) n++;
      return n;
   endfunction

   function automatic int arb(input logic [3:0] m, input int p);
      for (int i = 1; i <= NR; i++)
         if (m[(p + i) % NR]) return (p + i) % NR;
      return -1;
   endfunction

   task automatic serve(input logic [3:0] m, input logic [7:0] w0,
                        input logic [7:0] w1, input logic [7:0] w2,
                        input logic [7:0] w3, input int hold,
                        input bit keep);
      logic [7:0] wv [4];
      int g, e, lat, s0;
      bit got;
      wv[0] = w0; wv[1] = w1; wv[2] = w2; wv[3] = w3;
      req_data  = {w3, w2, w1, w0};
      req_valid = m;
      rsp_ready = (hold == 0);
      #1;
      got = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (|req_ready) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      chk("accept_seen", 32'(got), 1);
      if (!got) return;
      g = arb(m, ptr_m);
      ptr_m = g;
      e = n1101(wv[g]);
      chk("grant", 32'(req_ready), 32'(1 << g));
      s0 = seq_hi;
      tick();
      if (!keep) req_valid[g] = 1'b0;
      chk("clear_rst", 32'(det_rst), 1);
      chk("clear_din", 32'(det_in), 0);
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         chk("no_ready_busy", 32'(req_ready), 0);
         tick();
         lat++;
      end
      chk("latency", lat, DW + 2);
      chk("rsp_id", 32'(rsp_id), g);
      chk("rsp_count", 32'(rsp_count), e);
      chk("seq_pulses", seq_hi - s0, e);
      for (int h = 0; h < hold; h++) begin
         tick();
         chk("hold_valid", 32'(rsp_valid), 1);
         chk("hold_id", 32'(rsp_id), g);
         chk("hold_count", 32'(rsp_count), e);
         chk("hold_no_ready", 32'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      tick();
      chk("rsp_drop", 32'(rsp_valid), 0);
      chk("idle_busy", 32'(busy), 0);
   endtask

   initial begin
      int ok_cnt;
      int spur;
      rst_n     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      rsp_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_count", 32'(rsp_count), 0);
      chk("rst_det_in", 32'(det_in), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_det_rst", 32'(det_rst), 1);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      serve(4'b0001, 8'b1011_0100, 8'h00, 8'h00, 8'h00, 0, 0);
      serve(4'b1000, 8'hFF, 8'hFF, 8'hFF, 8'h00, 0, 0);
      for (int k = 0; k < 4; k++)
         serve(4'b0101, 8'($urandom), 8'h00, 8'($urandom), 8'h00, 0, 1);
      serve(4'b0010, 8'h00, 8'b0000_1011, 8'h00, 8'h00, 0, 0);
      serve(4'b0010, 8'h00, 8'b0110_0000, 8'h00, 8'h00, 0, 0);
      serve(4'b1010, 8'h00, 8'hDD, 8'h00, 8'h0D, 5, 0);

      for (int k = 0; k < 16; k++)
         serve(4'($urandom_range(1, 15)), 8'($urandom), 8'($urandom),
               8'($urandom), 8'($urandom), $urandom_range(0, 2), 0);

      req_data  = {8'h00, 8'hFF, 8'h00, 8'h00};
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      #1;
      ok_cnt = 0;
      for (int c = 0; c < 40 && !(|req_ready); c++) tick();
      chk("abort_grant", 32'(req_ready), 32'(1 << arb(4'b0100, ptr_m)));
      repeat (6) tick();
      rst_n = 1'b0;
      #1;
      chk("abort_det_rst", 32'(det_rst), 1);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_rsp_valid", 32'(rsp_valid), 0);
      chk("abort_no_ready", 32'(req_ready), 0);
      ptr_m = NR - 1;
      tick();
      tick();
      req_valid = '0;
      rst_n = 1'b1;
      spur = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (rsp_valid) spur++;
      end
      chk("abort_no_rsp", spur, 0);
      serve(4'b0101, 8'h0D, 8'h00, 8'hB4, 8'h00, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
